// File: rtl/ssd1331_pkg.sv
// Shared SSD1331 constants, opcodes and the command-parser state type.
package ssd1331_pkg;

  localparam int WIDTH  = 96;
  localparam int HEIGHT = 64;

  localparam logic [7:0] CMD_COL         = 8'h15;
  localparam logic [7:0] CMD_ROW         = 8'h75;
  localparam logic [7:0] CMD_REMAP       = 8'hA0;
  localparam logic [7:0] CMD_START_LINE  = 8'hA1;
  localparam logic [7:0] CMD_OFFSET      = 8'hA2;
  localparam logic [7:0] CMD_NORMAL      = 8'hA4;
  localparam logic [7:0] CMD_MASTER_CFG  = 8'hAD;
  localparam logic [7:0] CMD_DISPLAY_OFF = 8'hAE;
  localparam logic [7:0] CMD_DISPLAY_ON  = 8'hAF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COL_S = 3'd1,
    COL_E = 3'd2,
    ROW_S = 3'd3,
    ROW_E = 3'd4
  } parse_state_t;

  function automatic logic [7:0] clamp_addr(input logic [7:0] v, input logic [7:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// Oversampling SPI mode-0 byte receiver: synchronises the pins, detects
// rising sclk edges and emits one byte_valid pulse per complete byte.
module spi_byte_rx
  import ssd1331_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_csn,
  input  logic       i_sclk,
  input  logic       i_mosi,
  input  logic       i_dc,
  input  logic       i_resn,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_dc,
  output logic       o_resn_s
);

  // bit order in the synchroniser vectors: {resn, dc, mosi, sclk, csn}
  logic [4:0] r_sync1;
  logic [4:0] r_sync2;
  logic       r_sclk_prev;
  logic [6:0] r_shift;
  logic [2:0] r_cnt;

  logic w_csn_s;
  logic w_sclk_s;
  logic w_mosi_s;
  logic w_dc_s;
  logic w_rise;

  assign w_csn_s  = r_sync2[0];
  assign w_sclk_s = r_sync2[1];
  assign w_mosi_s = r_sync2[2];
  assign w_dc_s   = r_sync2[3];
  assign o_resn_s = r_sync2[4];
  assign w_rise   = w_sclk_s & ~r_sclk_prev;

  // two-flop synchronisers plus the delayed sclk used for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1     <= 5'b00000;
      r_sync2     <= 5'b00000;
      r_sclk_prev <= 1'b0;
    end else begin
      r_sync1     <= {i_resn, i_dc, i_mosi, i_sclk, i_csn};
      r_sync2     <= r_sync1;
      r_sclk_prev <= w_sclk_s;
    end
  end

  // shift register and bit counter; csn high or panel reset drops a partial byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift      <= 7'd0;
      r_cnt        <= 3'd0;
      o_byte_valid <= 1'b0;
      o_byte       <= 8'h00;
      o_dc         <= 1'b0;
    end else if (!o_resn_s || w_csn_s) begin
      r_cnt        <= 3'd0;
      o_byte_valid <= 1'b0;
    end else begin
      o_byte_valid <= 1'b0;
      if (w_rise) begin
        r_shift <= {r_shift[5:0], w_mosi_s};
        r_cnt   <= r_cnt + 3'd1;
        if (r_cnt == 3'd7) begin
          o_byte_valid <= 1'b1;
          o_byte       <= {r_shift, w_mosi_s};
          o_dc         <= w_dc_s;
        end
      end
    end
  end

endmodule

// File: rtl/spi_oled_sink.sv
// SSD1331 receive-side model: parses window commands and turns each data
// byte into a pixel-write strobe at the current cursor.
module spi_oled_sink
  import ssd1331_pkg::*;
#(
  parameter int         WIDTH   = ssd1331_pkg::WIDTH,
  parameter int         HEIGHT  = ssd1331_pkg::HEIGHT,
  parameter logic [7:0] CMD_COL = ssd1331_pkg::CMD_COL,
  parameter logic [7:0] CMD_ROW = ssd1331_pkg::CMD_ROW
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       oled_csn,
  input  logic       oled_clk,
  input  logic       oled_mosi,
  input  logic       oled_dc,
  input  logic       oled_resn,
  output logic       pixel_valid,
  output logic [7:0] pixel_x,
  output logic [5:0] pixel_y,
  output logic [7:0] pixel_color,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       frame_done
);

  localparam logic [7:0] X_MAX = 8'(WIDTH - 1);
  localparam logic [5:0] Y_MAX = 6'(HEIGHT - 1);

  logic       w_byte_valid;
  logic [7:0] w_byte;
  logic       w_dc;
  logic       w_resn_s;

  parse_state_t r_state;
  parse_state_t w_state_n;
  logic         w_cmd_hit;

  logic [7:0] r_col_start, r_col_end, r_x;
  logic [5:0] r_row_start, r_row_end, r_y;
  logic [7:0] w_x_next;
  logic [5:0] w_y_next;
  logic [7:0] w_col_val;
  logic [5:0] w_row_val;

  spi_byte_rx u_rx (
    .clk          (clk),
    .reset        (reset),
    .i_csn        (oled_csn),
    .i_sclk       (oled_clk),
    .i_mosi       (oled_mosi),
    .i_dc         (oled_dc),
    .i_resn       (oled_resn),
    .o_byte_valid (w_byte_valid),
    .o_byte       (w_byte),
    .o_dc         (w_dc),
    .o_resn_s     (w_resn_s)
  );

  assign w_col_val = clamp_addr(w_byte, X_MAX);
  assign w_row_val = (w_byte > {2'b00, Y_MAX}) ? Y_MAX : w_byte[5:0];

  // cursor advance: wrap at window end or at the panel edge (start > end case)
  always_comb begin
    w_x_next = r_x + 8'd1;
    w_y_next = r_y;
    if ((r_x == r_col_end) || (r_x == X_MAX)) begin
      w_x_next = r_col_start;
      if ((r_y == r_row_end) || (r_y == Y_MAX)) begin
        w_y_next = r_row_start;
      end else begin
        w_y_next = r_y + 6'd1;
      end
    end else begin
      w_y_next = r_y;
    end
  end

  // parser next state; only command bytes move the FSM
  always_comb begin
    w_state_n = r_state;
    w_cmd_hit = 1'b0;
    if (w_byte_valid && !w_dc) begin
      case (r_state)
        IDLE: begin
          if (w_byte == CMD_COL) begin
            w_state_n = COL_S;
          end else if (w_byte == CMD_ROW) begin
            w_state_n = ROW_S;
          end else begin
            w_cmd_hit = 1'b1;
          end
        end
        COL_S:   w_state_n = COL_E;
        COL_E:   w_state_n = IDLE;
        ROW_S:   w_state_n = ROW_E;
        ROW_E:   w_state_n = IDLE;
        default: w_state_n = IDLE;
      endcase
    end else begin
      w_state_n = r_state;
    end
  end

  // parser state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else if (!w_resn_s) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // window, cursor and output strobes; panel reset wins over a completing byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_valid <= 1'b0;
      pixel_x     <= 8'd0;
      pixel_y     <= 6'd0;
      pixel_color <= 8'h00;
      cmd_valid   <= 1'b0;
      cmd_byte    <= 8'h00;
      frame_done  <= 1'b0;
      r_col_start <= 8'd0;
      r_col_end   <= X_MAX;
      r_row_start <= 6'd0;
      r_row_end   <= Y_MAX;
      r_x         <= 8'd0;
      r_y         <= 6'd0;
    end else begin
      pixel_valid <= 1'b0;
      cmd_valid   <= 1'b0;
      frame_done  <= 1'b0;
      if (!w_resn_s) begin
        r_col_start <= 8'd0;
        r_col_end   <= X_MAX;
        r_row_start <= 6'd0;
        r_row_end   <= Y_MAX;
        r_x         <= 8'd0;
        r_y         <= 6'd0;
      end else if (w_byte_valid && w_dc) begin
        pixel_valid <= 1'b1;
        pixel_x     <= r_x;
        pixel_y     <= r_y;
        pixel_color <= w_byte;
        frame_done  <= (r_x == r_col_end) && (r_y == r_row_end);
        r_x         <= w_x_next;
        r_y         <= w_y_next;
      end else if (w_byte_valid) begin
        case (r_state)
          IDLE: begin
            if (w_cmd_hit) begin
              cmd_valid <= 1'b1;
              cmd_byte  <= w_byte;
            end
          end
          COL_S: r_col_start <= w_col_val;
          COL_E: begin
            r_col_end <= w_col_val;
            r_x       <= r_col_start;
          end
          ROW_S: r_row_start <= w_row_val;
          ROW_E: begin
            r_row_end <= w_row_val;
            r_y       <= r_row_start;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
